// File: rtl/data_memory_arbiter.sv
// Round-robin request/acknowledge arbiter and access sequencer for the shared
// single-port data memory (port 0: load/store stage, port 1: debug/DMA loader).
module data_memory_arbiter #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req0,
  input  logic                  we0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] wdata0,
  output logic [DATA_WIDTH-1:0] rdata0,
  output logic                  ack0,
  input  logic                  req1,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic                  ack1,
  output logic [ADDR_WIDTH-1:0] DataMemoryAddressBus,
  output logic [DATA_WIDTH-1:0] DataMemoryInputBus,
  input  logic [DATA_WIDTH-1:0] DataMemoryOutputBus,
  output logic                  sig_enable_data_memory_write,
  output logic                  sig_enable_data_memory_read,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WAIT,
    DONE
  } state_t;

  state_t                state_q, state_d;
  logic                  last_grant_q, last_grant_d;
  logic                  gnt_q, gnt_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d;
  logic [DATA_WIDTH-1:0] rdata1_q, rdata1_d;
  logic                  ack0_q, ack0_d;
  logic                  ack1_q, ack1_d;
  logic [ADDR_WIDTH-1:0] abus_q, abus_d;
  logic [DATA_WIDTH-1:0] dbus_q, dbus_d;
  logic                  wen_q, wen_d;
  logic                  ren_q, ren_d;
  logic                  busy_q, busy_d;
  logic                  pick;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    gnt_d        = gnt_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    ack0_d       = 1'b0;
    ack1_d       = 1'b0;
    abus_d       = '0;
    dbus_d       = '0;
    wen_d        = 1'b0;
    ren_d        = 1'b0;
    pick         = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          // On a tie the port that was not served last wins.
          pick         = (req0 && req1) ? ~last_grant_q : req1;
          gnt_d        = pick;
          last_grant_d = pick;
          we_d         = pick ? we1 : we0;
          addr_d       = pick ? addr1 : addr0;
          wdata_d      = pick ? wdata1 : wdata0;
          state_d      = ACCESS;
          abus_d       = addr_d;
          if (we_d) begin
            dbus_d = wdata_d;
            wen_d  = 1'b1;
          end else begin
            ren_d  = 1'b1;
          end
        end
      end
      ACCESS: begin
        if (we_q) begin
          state_d = DONE;
          ack0_d  = ~gnt_q;
          ack1_d  = gnt_q;
        end else begin
          state_d = WAIT;
          abus_d  = addr_q;
          ren_d   = 1'b1;
        end
      end
      WAIT: begin
        state_d = DONE;
        if (gnt_q) begin
          rdata1_d = DataMemoryOutputBus;
          ack1_d   = 1'b1;
        end else begin
          rdata0_d = DataMemoryOutputBus;
          ack0_d   = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      gnt_q        <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      abus_q       <= '0;
      dbus_q       <= '0;
      wen_q        <= 1'b0;
      ren_q        <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      gnt_q        <= gnt_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
      abus_q       <= abus_d;
      dbus_q       <= dbus_d;
      wen_q        <= wen_d;
      ren_q        <= ren_d;
      busy_q       <= busy_d;
    end
  end

  assign rdata0                       = rdata0_q;
  assign rdata1                       = rdata1_q;
  assign ack0                         = ack0_q;
  assign ack1                         = ack1_q;
  assign DataMemoryAddressBus         = abus_q;
  assign DataMemoryInputBus           = dbus_q;
  assign sig_enable_data_memory_write = wen_q;
  assign sig_enable_data_memory_read  = ren_q;
  assign busy                         = busy_q;

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Scoreboard bench for data_memory_arbiter: directed transactions push their
// expected grant order and results; a negedge monitor checks the buses and acks.
module tb_data_memory_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
  logic [15:0] addr0 = '0, wdata0 = '0, addr1 = '0, wdata1 = '0;
  logic [15:0] rdata0, rdata1, abus, dbus, mem_dout;
  logic        ack0, ack1, wen, ren, busy;

  always #5 clock = ~clock;

  data_memory_arbiter #(.DATA_WIDTH(16), .ADDR_WIDTH(16)) dut (
    .clock(clock), .reset(reset),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .rdata0(rdata0), .ack0(ack0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .rdata1(rdata1), .ack1(ack1),
    .DataMemoryAddressBus(abus), .DataMemoryInputBus(dbus), .DataMemoryOutputBus(mem_dout),
    .sig_enable_data_memory_write(wen), .sig_enable_data_memory_read(ren), .busy(busy)
  );

  // Synchronous single-port memory: read data valid one cycle after read enable.
  logic [15:0] mem [0:255];
  logic        pk_en = 1'b0;
  logic [7:0]  pk_addr = '0;
  logic [15:0] pk_data = '0;
  always @(posedge clock) begin
    if (pk_en) mem[pk_addr] <= pk_data;
    else if (wen) mem[abus[7:0]] <= dbus;
    if (ren) mem_dout <= mem[abus[7:0]];
  end

  typedef struct {
    int          port;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
  } exp_t;

  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          ack_cyc[2];
  int          nack[2];
  int          wen_cnt = 0;
  logic [15:0] rm[2];
  logic        prev_wen = 1'b0, prev_ack0 = 1'b0, prev_ack1 = 1'b0;

  function automatic void chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic void chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b (t=%0t)", name, act, exp, $time);
    end
  endfunction

  always @(posedge clock) cyc++;

  // Monitor
  always @(negedge clock) begin
    exp_t e;
    int   p;
    if (reset) begin
      rm[0] = '0;
      rm[1] = '0;
      prev_wen = 1'b0;
      prev_ack0 = 1'b0;
      prev_ack1 = 1'b0;
    end else begin
      chk1("en_exclusive", wen && ren, 1'b0);
      if (wen) begin
        wen_cnt++;
        chk1("wen_not_consecutive", prev_wen, 1'b0);
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL wen_unexpected: write enable with no pending transaction addr=%0h", abus);
        end else begin
          chk1("wen_op", sb[0].we, 1'b1);
          chk16("wen_addr", abus, sb[0].addr);
          chk16("wen_data", dbus, sb[0].wdata);
        end
      end
      if (ren) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL ren_unexpected: read enable with no pending transaction addr=%0h", abus);
        end else begin
          chk1("ren_op", sb[0].we, 1'b0);
          chk16("ren_addr", abus, sb[0].addr);
        end
      end
      if (!wen && !ren) begin
        chk16("idle_abus", abus, 16'h0000);
        chk16("idle_dbus", dbus, 16'h0000);
      end
      chk1("ack_exclusive", ack0 && ack1, 1'b0);
      if (ack0) chk1("ack0_one_cycle", prev_ack0, 1'b0);
      if (ack1) chk1("ack1_one_cycle", prev_ack1, 1'b0);
      if (ack0 || ack1) begin
        p = ack1 ? 1 : 0;
        ack_cyc[p] = cyc;
        nack[p]++;
        chk1("busy_at_ack", busy, 1'b1);
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL ack_unexpected: ack on port %0d with no pending transaction", p);
        end else begin
          e = sb.pop_front();
          chk16("grant_port", 16'(p), 16'(e.port));
          if (!e.we) rm[p] = e.rdata;
        end
      end
      chk16("rdata0_model", rdata0, rm[0]);
      chk16("rdata1_model", rdata1, rm[1]);
      prev_wen = wen;
      prev_ack0 = ack0;
      prev_ack1 = ack1;
    end
  end

  task automatic poke(input logic [7:0] a, input logic [15:0] d);
    pk_en = 1'b1; pk_addr = a; pk_data = d;
    @(posedge clock); #1;
    pk_en = 1'b0;
  endtask

  // Called at posedge+1; returns latency in cycles counted from the next edge.
  task automatic drive(input int p, input logic w, input logic [15:0] a,
                       input logic [15:0] d, output int lat);
    int n;
    bit got;
    n = 0;
    got = 1'b0;
    if (p == 0) begin req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d; end
    else        begin req1 = 1'b1; we1 = w; addr1 = a; wdata1 = d; end
    @(posedge clock);
    while (!got && n < 40) begin
      @(negedge clock);
      n++;
      got = (p == 0) ? ack0 : ack1;
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL ack_timeout: port %0d no ack within 40 cycles", p);
    end
    lat = n;
    @(posedge clock); #1;
    if (p == 0) req0 = 1'b0;
    else        req1 = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clock); #3;
    reset = 1'b1;
    #10;
    reset = 1'b0;
    @(posedge clock); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int l0, l1, w0, n1;
    nack[0] = 0; nack[1] = 0;
    ack_cyc[0] = 0; ack_cyc[1] = 0;
    rm[0] = '0; rm[1] = '0;

    poke(8'h02, 16'hAAAA);
    poke(8'h03, 16'h5555);
    poke(8'h04, 16'h1234);
    poke(8'h20, 16'h7777);
    reset = 1'b0;
    @(posedge clock); #1;

    // 1: mid-cycle reset, then idle
    @(posedge clock); #3;
    reset = 1'b1;
    #1;
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_wen", wen, 1'b0);
    chk1("rst_ren", ren, 1'b0);
    chk1("rst_ack0", ack0, 1'b0);
    chk1("rst_ack1", ack1, 1'b0);
    chk16("rst_rdata0", rdata0, 16'h0000);
    chk16("rst_rdata1", rdata1, 16'h0000);
    chk16("rst_abus", abus, 16'h0000);
    chk16("rst_dbus", dbus, 16'h0000);
    #10;
    reset = 1'b0;
    @(posedge clock); #1;
    repeat (5) begin
      @(negedge clock);
      chk1("idle_wen", wen, 1'b0);
      chk1("idle_ren", ren, 1'b0);
      chk1("idle_busy", busy, 1'b0);
    end
    @(posedge clock); #1;

    // 2: port 0 write then read back
    w0 = wen_cnt;
    sb.push_back('{0, 1'b1, 16'h0001, 16'h0010, 16'h0000});
    drive(0, 1'b1, 16'h0001, 16'h0010, l0);
    chk16("t2_write_latency", 16'(l0), 16'd2);
    chk16("t2_wen_cycles", 16'(wen_cnt - w0), 16'd1);
    sb.push_back('{0, 1'b0, 16'h0001, 16'h0000, 16'h0010});
    drive(0, 1'b0, 16'h0001, 16'h0000, l0);
    chk16("t2_read_latency", 16'(l0), 16'd3);
    chk16("t2_rdata0", rdata0, 16'h0010);
    chk16("t2_rdata1", rdata1, 16'h0000);

    // 3: simultaneous reads, port 0 first after reset
    do_reset();
    sb.push_back('{0, 1'b0, 16'h0002, 16'h0000, 16'hAAAA});
    sb.push_back('{1, 1'b0, 16'h0003, 16'h0000, 16'h5555});
    fork
      drive(0, 1'b0, 16'h0002, 16'h0000, l0);
      drive(1, 1'b0, 16'h0003, 16'h0000, l1);
    join
    chk16("t3_lat0", 16'(l0), 16'd3);
    chk16("t3_lat1", 16'(l1), 16'd7);
    chk16("t3_ack_spacing", 16'(ack_cyc[1] - ack_cyc[0]), 16'd4);
    chk16("t3_rdata0", rdata0, 16'hAAAA);
    chk16("t3_rdata1", rdata1, 16'h5555);

    // 4: both hold writes continuously
    for (int i = 0; i < 3; i++) begin
      sb.push_back('{0, 1'b1, 16'(16'h0030 + i), 16'(16'h1000 + i), 16'h0000});
      sb.push_back('{1, 1'b1, 16'(16'h0040 + i), 16'(16'h2000 + i), 16'h0000});
    end
    w0 = wen_cnt;
    fork
      begin
        for (int i = 0; i < 3; i++)
          drive(0, 1'b1, 16'(16'h0030 + i), 16'(16'h1000 + i), l0);
      end
      begin
        for (int j = 0; j < 3; j++)
          drive(1, 1'b1, 16'(16'h0040 + j), 16'(16'h2000 + j), l1);
      end
    join
    chk16("t4_wen_cycles", 16'(wen_cnt - w0), 16'd6);
    chk16("t4_sb_drained", 16'(sb.size()), 16'd0);

    // 5: port 1 read aborted by reset during WAIT
    n1 = nack[1];
    sb.push_back('{1, 1'b0, 16'h0004, 16'h0000, 16'h1234});
    req1 = 1'b1; we1 = 1'b0; addr1 = 16'h0004; wdata1 = 16'h0000;
    @(posedge clock);
    @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    chk1("t5_ren_drop", ren, 1'b0);
    chk1("t5_wen_drop", wen, 1'b0);
    chk1("t5_busy_drop", busy, 1'b0);
    chk1("t5_ack1", ack1, 1'b0);
    sb.delete();
    req1 = 1'b0;
    repeat (2) @(posedge clock);
    #2;
    chk16("t5_rdata1_rst", rdata1, 16'h0000);
    reset = 1'b0;
    @(posedge clock); #1;
    repeat (3) @(posedge clock);
    #1;
    chk16("t5_no_ack1", 16'(nack[1] - n1), 16'd0);
    sb.push_back('{1, 1'b0, 16'h0004, 16'h0000, 16'h1234});
    drive(1, 1'b0, 16'h0004, 16'h0000, l1);
    chk16("t5_reissue_latency", 16'(l1), 16'd3);
    chk16("t5_rdata1", rdata1, 16'h1234);

    // 6: port 0 changes addr/we during ACCESS
    sb.push_back('{0, 1'b1, 16'h0010, 16'hBEEF, 16'h0000});
    fork
      drive(0, 1'b1, 16'h0010, 16'hBEEF, l0);
      begin
        @(posedge clock);
        #2;
        addr0 = 16'h0020; we0 = 1'b0; wdata0 = 16'h0000;
      end
    join
    chk16("t6_write_latency", 16'(l0), 16'd2);
    sb.push_back('{0, 1'b0, 16'h0010, 16'h0000, 16'hBEEF});
    drive(0, 1'b0, 16'h0010, 16'h0000, l0);
    chk16("t6_rdata_orig", rdata0, 16'hBEEF);
    sb.push_back('{0, 1'b0, 16'h0020, 16'h0000, 16'h7777});
    drive(0, 1'b0, 16'h0020, 16'h0000, l0);
    chk16("t6_rdata_other", rdata0, 16'h7777);

    repeat (3) @(posedge clock);
    chk16("final_sb_empty", 16'(sb.size()), 16'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
